option_value_entry: RTL and testbench

- Digit-entry decoder for the options menu; the inverse of the options decimalizer (binary to decimal digits).
- Accepts decimal keypresses for the selected option value, echoes them as digits for on-screen display, and converts them to binary.
- On commit it clamps the result into [min_value, max_value] and presents it to the game state machine as a one-cycle update pulse.

---
 rtl/option_value_entry_pkg.sv | 30 +++
 rtl/option_value_entry_if.sv | 46 ++++
 rtl/option_value_entry_bcd_serial_to_bin.sv | 47 ++++
 rtl/option_value_entry.sv | 166 ++++++++++++++++
 tb/tb_option_value_entry.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/option_value_entry_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : option_value_entry_pkg
//  Description : Shared types and constants for options-menu digit entry.
//                Holds the entry FSM states, the digit types and the
//                largest legal decimal key value.
//  Revision    : 1.0 - initial release
// ============================================================================
package option_value_entry_pkg;

    // Decimal length of an option field shown on screen
    localparam int OPT_DEC_LEN = 2;

    // Largest legal decimal keypress
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    typedef logic [3:0] digit_t;

    // Digit array shared with the decimalizer output struct; [0] is the MS digit
    typedef digit_t digit_arr_t [OPT_DEC_LEN];

    typedef enum logic [1:0] {
        ENTRY_IDLE    = 2'd0,
        ENTRY_EDIT    = 2'd1,
        ENTRY_CONVERT = 2'd2,
        ENTRY_CLAMP   = 2'd3
    } entry_state_t;

endpackage
`default_nettype wire

// File: rtl/option_value_entry_if.sv
`default_nettype none
// ============================================================================
//  Module      : option_value_entry_if
//  Description : Keypad / menu-side bundle for the option value entry block.
//                The master drives key events and bounds; the slave returns
//                the echoed digits and the committed value.
//  Revision    : 1.0 - initial release
// ============================================================================
interface option_value_entry_if #(
    parameter int W_VAL    = 8,
    parameter int N_DIGITS = 2
);
    import option_value_entry_pkg::*;

    logic                          start;
    logic [W_VAL-1:0]              min_value;
    logic [W_VAL-1:0]              max_value;
    logic                          digit_valid;
    logic [3:0]                    digit;
    logic                          backspace;
    logic                          commit;
    logic                          cancel;
    logic                          editing;
    logic                          busy;
    digit_t                        digits_out [N_DIGITS];
    logic [$clog2(N_DIGITS+1)-1:0] digit_count;
    logic [W_VAL-1:0]              value_out;
    logic                          value_valid;
    logic                          clamped;

    modport master (
        output start, min_value, max_value, digit_valid, digit,
               backspace, commit, cancel,
        input  editing, busy, digits_out, digit_count,
               value_out, value_valid, clamped
    );

    modport slave (
        input  start, min_value, max_value, digit_valid, digit,
               backspace, commit, cancel,
        output editing, busy, digits_out, digit_count,
               value_out, value_valid, clamped
    );

endinterface
`default_nettype wire

// File: rtl/option_value_entry_bcd_serial_to_bin.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_to_bin
//  Description : Serial decimal-to-binary converter. Consumes one buffered
//                digit per cycle, most significant first, using Horner's
//                rule acc = acc*10 + digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_to_bin
    import option_value_entry_pkg::*;
#(
    parameter int N_DIGITS = 2,
    parameter int ACC_W    = 4 * N_DIGITS
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clear,
    input  wire logic             i_run,
    input  wire digit_t           i_digits [N_DIGITS],
    output logic [ACC_W-1:0]      o_acc,
    output logic                  o_last
);

    localparam int c_idx_w = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [ACC_W-1:0]   r_acc;
    logic [c_idx_w-1:0] r_idx;

    // Accumulator and digit index: clear on commit, then one x10+digit step per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (i_run) begin
            r_acc <= (r_acc << 3) + (r_acc << 1) + ACC_W'(i_digits[r_idx]);
            r_idx <= r_idx + 1'b1;
        end
    end

    assign o_acc  = r_acc;
    assign o_last = (r_idx == c_idx_w'(N_DIGITS - 1));

endmodule
`default_nettype wire

// File: rtl/option_value_entry.sv
`default_nettype none
// ============================================================================
//  Module      : option_value_entry
//  Description : Options-menu digit entry. Collects decimal keypresses,
//                echoes them for display, converts to binary on commit,
//                clamps into [min_value, max_value] and pulses value_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module option_value_entry
    import option_value_entry_pkg::*;
#(
    parameter int W_VAL    = 8,
    parameter int N_DIGITS = 2,
    parameter int ACC_W    = 4 * N_DIGITS
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    option_value_entry_if.slave    bus
);

    localparam int c_cnt_w = $clog2(N_DIGITS + 1);
    localparam int c_cmp_w = (ACC_W > W_VAL) ? ACC_W : W_VAL;

    entry_state_t       r_state;
    entry_state_t       w_state_next;
    digit_t             r_buf      [N_DIGITS];
    digit_t             w_buf_next [N_DIGITS];
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               w_conv_clear;
    logic               w_conv_run;
    logic               w_conv_last;
    logic [ACC_W-1:0]   w_acc;
    logic [c_cmp_w-1:0] w_acc_ext;
    logic [c_cmp_w-1:0] w_min_ext;
    logic [c_cmp_w-1:0] w_max_ext;
    logic [W_VAL-1:0]   w_clamp_value;
    logic               w_clamp_hit;
    logic [W_VAL-1:0]   r_value;
    logic               r_value_valid;
    logic               r_clamped;
    logic               r_editing;
    logic               r_busy;

    bcd_serial_to_bin #(
        .N_DIGITS (N_DIGITS),
        .ACC_W    (ACC_W)
    ) u_conv (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_conv_clear),
        .i_run    (w_conv_run),
        .i_digits (r_buf),
        .o_acc    (w_acc),
        .o_last   (w_conv_last)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ENTRY_IDLE;
        else        r_state <= w_state_next;
    end

    // Next state and digit-buffer edits; only the highest-priority EDIT event acts
    always_comb begin
        w_state_next = r_state;
        w_buf_next   = r_buf;
        w_cnt_next   = r_cnt;
        w_conv_clear = 1'b0;
        w_conv_run   = 1'b0;
        case (r_state)
            ENTRY_IDLE: begin
                w_buf_next = '{default: '0};
                w_cnt_next = '0;
                // A start landing on the value_valid cycle still belongs to the
                // finishing session and is dropped
                if (bus.start && !r_value_valid) w_state_next = ENTRY_EDIT;
            end
            ENTRY_EDIT: begin
                if (bus.cancel || (bus.commit && r_cnt == '0)) begin
                    w_state_next = ENTRY_IDLE;
                    w_buf_next   = '{default: '0};
                    w_cnt_next   = '0;
                end else if (bus.commit) begin
                    w_state_next = ENTRY_CONVERT;
                    w_conv_clear = 1'b1;
                end else if (bus.backspace) begin
                    if (r_cnt != '0) begin
                        w_buf_next[0] = '0;
                        for (int k = 1; k < N_DIGITS; k++) w_buf_next[k] = r_buf[k-1];
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end else if (bus.digit_valid && bus.digit <= DIGIT_MAX &&
                             r_cnt < c_cnt_w'(N_DIGITS)) begin
                    for (int k = 0; k < N_DIGITS - 1; k++) w_buf_next[k] = r_buf[k+1];
                    w_buf_next[N_DIGITS-1] = bus.digit;
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ENTRY_CONVERT: begin
                w_conv_run = 1'b1;
                if (w_conv_last) w_state_next = ENTRY_CLAMP;
            end
            ENTRY_CLAMP: begin
                w_state_next = ENTRY_IDLE;
                w_buf_next   = '{default: '0};
                w_cnt_next   = '0;
            end
            default: w_state_next = ENTRY_IDLE;
        endcase
    end

    // Digit buffer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '{default: '0};
            r_cnt <= '0;
        end else begin
            r_buf <= w_buf_next;
            r_cnt <= w_cnt_next;
        end
    end

    // Clamp the converted value; the min check wins if the bounds are inverted
    always_comb begin
        w_acc_ext     = c_cmp_w'(w_acc);
        w_min_ext     = c_cmp_w'(bus.min_value);
        w_max_ext     = c_cmp_w'(bus.max_value);
        w_clamp_value = W_VAL'(w_acc_ext);
        w_clamp_hit   = 1'b0;
        if (w_acc_ext < w_min_ext) begin
            w_clamp_value = bus.min_value;
            w_clamp_hit   = 1'b1;
        end else if (w_acc_ext > w_max_ext) begin
            w_clamp_value = bus.max_value;
            w_clamp_hit   = 1'b1;
        end
    end

    // Registered status flags and the committed value with its one-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_editing     <= 1'b0;
            r_busy        <= 1'b0;
            r_value_valid <= 1'b0;
            r_clamped     <= 1'b0;
            r_value       <= '0;
        end else begin
            r_editing     <= (w_state_next == ENTRY_EDIT);
            r_busy        <= (w_state_next == ENTRY_CONVERT) || (w_state_next == ENTRY_CLAMP);
            r_value_valid <= (r_state == ENTRY_CLAMP);
            r_clamped     <= (r_state == ENTRY_CLAMP) && w_clamp_hit;
            if (r_state == ENTRY_CLAMP) r_value <= w_clamp_value;
        end
    end

    assign bus.editing     = r_editing;
    assign bus.busy        = r_busy;
    assign bus.digits_out  = r_buf;
    assign bus.digit_count = r_cnt;
    assign bus.value_out   = r_value;
    assign bus.value_valid = r_value_valid;
    assign bus.clamped     = r_clamped;

endmodule
`default_nettype wire

// File: tb/tb_option_value_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_option_value_entry
//  Description : Self-checking bench for option_value_entry. Committed
//                results are queued when commit is driven and compared
//                when value_valid pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_option_value_entry;

    typedef struct {
        logic [7:0] value;
        logic       clamped;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb [$];

    option_value_entry_if #(.W_VAL(8), .N_DIGITS(2)) bus ();

    option_value_entry #(.W_VAL(8), .N_DIGITS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Cycle counter used for the commit-to-pulse latency check
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic key(input logic [3:0] d);
        bus.digit       = d;
        bus.digit_valid = 1'b1;
        tick();
        bus.digit_valid = 1'b0;
    endtask

    task automatic do_commit(input logic [7:0] v, input logic c);
        exp_t e;
        e.value   = v;
        e.clamped = c;
        e.cyc     = cyc;
        sb.push_back(e);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        tick();
        check("pending_results", sb.size(), 0);
    endtask

    function automatic logic [7:0] digits_packed();
        return {bus.digits_out[0], bus.digits_out[1]};
    endfunction

    // Scoreboard compare on every value_valid pulse
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.value_valid === 1'b1) begin
            check("pulse_expected", sb.size(), 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("value_out", bus.value_out, e.value);
                check("clamped",   bus.clamped,   e.clamped);
                check("latency",   cyc - e.cyc,   4);
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.min_value   = 8'd0;
        bus.max_value   = 8'd0;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.backspace   = 1'b0;
        bus.commit      = 1'b0;
        bus.cancel      = 1'b0;
        tick();
        tick();
        check("rst_editing",     bus.editing,     0);
        check("rst_busy",        bus.busy,        0);
        check("rst_value_valid", bus.value_valid, 0);
        check("rst_clamped",     bus.clamped,     0);
        check("rst_digits",      digits_packed(), 8'h00);
        check("rst_count",       bus.digit_count, 0);
        check("rst_value",       bus.value_out,   0);
        rst_n = 1'b1;
        tick();

        // Reset mid-EDIT after digits 4,2
        do_start();
        key(4'd4);
        key(4'd2);
        check("pre_rst_count",  bus.digit_count, 2);
        check("pre_rst_digits", digits_packed(), 8'h42);
        rst_n = 1'b0;
        #2;
        check("mid_rst_editing", bus.editing,     0);
        check("mid_rst_count",   bus.digit_count, 0);
        check("mid_rst_digits",  digits_packed(), 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        check("post_rst_editing", bus.editing,     1);
        check("post_rst_count",   bus.digit_count, 0);

        // Session 1: 15 within [1,21]
        bus.min_value = 8'd1;
        bus.max_value = 8'd21;
        key(4'd1);
        key(4'd5);
        check("s1_digits", digits_packed(), 8'h15);
        check("s1_count",  bus.digit_count, 2);
        do_commit(8'd15, 1'b0);
        check("s1_busy",    bus.busy,    1);
        check("s1_editing", bus.editing, 0);
        wait_done();

        // Session 2: 99 clamps to max 20, third digit ignored
        bus.min_value = 8'd2;
        bus.max_value = 8'd20;
        do_start();
        key(4'd9);
        key(4'd9);
        key(4'd7);
        check("s2_count",  bus.digit_count, 2);
        check("s2_digits", digits_packed(), 8'h99);
        do_commit(8'd20, 1'b1);
        wait_done();

        // Session 3: 0 clamps to min 1
        bus.min_value = 8'd1;
        bus.max_value = 8'd21;
        do_start();
        key(4'd0);
        do_commit(8'd1, 1'b1);
        wait_done();

        // Session 4: backspace editing, commit beats digit_valid
        bus.min_value = 8'd0;
        bus.max_value = 8'd99;
        do_start();
        key(4'd3);
        key(4'd7);
        bus.backspace = 1'b1;
        tick();
        bus.backspace = 1'b0;
        check("s4_bs_digits", digits_packed(), 8'h03);
        check("s4_bs_count",  bus.digit_count, 1);
        key(4'd2);
        check("s4_digits", digits_packed(), 8'h32);
        bus.digit       = 4'd5;
        bus.digit_valid = 1'b1;
        do_commit(8'd32, 1'b0);
        bus.digit_valid = 1'b0;
        wait_done();
        check("s4_value_hold", bus.value_out, 8'd32);

        // Session 5: cancel leaves value_out alone
        do_start();
        key(4'd6);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("s5_editing", bus.editing,     0);
        check("s5_count",   bus.digit_count, 0);
        repeat (6) tick();
        check("s5_value_hold", bus.value_out, 8'd32);

        // Session 6: illegal digit, empty commit, start while busy / on pulse
        do_start();
        key(4'hB);
        check("s6_bad_digit_count", bus.digit_count, 0);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        check("s6_empty_commit_editing", bus.editing, 0);
        check("s6_empty_commit_busy",    bus.busy,    0);
        repeat (6) tick();
        check("s6_empty_commit_value", bus.value_out, 8'd32);
        do_start();
        key(4'd1);
        do_commit(8'd1, 1'b0);
        bus.start = 1'b1;
        tick();
        tick();
        tick();
        check("s6_pulse_cycle", bus.value_valid, 1);
        tick();
        bus.start = 1'b0;
        check("s6_start_ignored_editing", bus.editing, 0);
        check("s6_start_ignored_busy",    bus.busy,    0);
        wait_done();
        check("s6_value", bus.value_out, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
